cdb_arbiter: RTL

Shares the single common data bus (CDB) between N result producers (ALU, load unit, branch unit). Each producer pushes results into a private 2-entry queue. A round-robin arbiter picks one queue head per cycle and drives it onto a registered broadcast, which feeds the register file, the reservation stations and the ROB. It drops all in-flight results on a mispredict flush.

---
 rtl/cdb_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// cdb_arbiter: per-requester result queues sharing one registered CDB broadcast; rev 1.0
// CDB_RR_EN selects round-robin arbitration, otherwise lowest non-empty index wins.
`ifndef ROBBW
`define ROBBW 6
`endif

module cdb_arbiter #(
  parameter  int N     = 3,
  parameter  int DEPTH = 2,
  localparam int SW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   jump_wrong,
  input  logic [N-1:0]           req_valid,
  input  logic [N*`ROBBW-1:0]    req_rob_id,
  input  logic [N*32-1:0]        req_val,
  output logic [N-1:0]           req_ready,
  output logic                   cdb_flag,
  output logic [`ROBBW-1:0]      cdb_rob_id,
  output logic [31:0]            cdb_val,
  output logic [SW-1:0]          cdb_src
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [`ROBBW-1:0] q_tag [N][DEPTH];
  logic [31:0]       q_val [N][DEPTH];
  logic [PW-1:0]     head  [N];
  logic [PW-1:0]     tail  [N];
  logic [CW-1:0]     count [N];

  logic [N-1:0]  nonempty;
  logic [N-1:0]  push;
  logic [N-1:0]  keep;
  logic [N-1:0]  pop;
  logic [SW-1:0] win;
  logic          win_found;

  // Ready looks only at registered occupancy; tag-0 pushes handshake but are not stored.
  always_comb begin
    nonempty  = '0;
    req_ready = '0;
    push      = '0;
    keep      = '0;
    pop       = '0;
    for (int i = 0; i < N; i++) begin
      nonempty[i]  = (count[i] != '0);
      req_ready[i] = rst && rdy && (count[i] != CW'(DEPTH));
      push[i]      = req_valid[i] && req_ready[i] && !jump_wrong;
      keep[i]      = push[i] && (req_rob_id[i*`ROBBW +: `ROBBW] != '0);
      pop[i]       = rdy && !jump_wrong && win_found && (win == SW'(i));
    end
  end

`ifdef CDB_RR_EN
  logic [SW-1:0] last;
  logic [SW-1:0] idx;

  always_comb begin
    win       = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = SW'((int'(last) + k) % N);
      if (!win_found && nonempty[idx]) begin
        win       = idx;
        win_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= SW'(N - 1);
    end else if (jump_wrong) begin
      last <= SW'(N - 1);
    end else if (rdy && win_found) begin
      last <= win;
    end
  end
`else
  always_comb begin
    win       = '0;
    win_found = |nonempty;
    for (int k = N - 1; k >= 0; k--) begin
      if (nonempty[k]) win = SW'(k);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
    end else if (jump_wrong) begin
      for (int i = 0; i < N; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
    end else if (rdy) begin
      for (int i = 0; i < N; i++) begin
        if (keep[i]) tail[i] <= tail[i] + 1'b1;
        if (pop[i])  head[i] <= head[i] + 1'b1;
        count[i] <= count[i] + CW'(keep[i]) - CW'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (keep[i]) begin
        q_tag[i][tail[i]] <= req_rob_id[i*`ROBBW +: `ROBBW];
        q_val[i][tail[i]] <= req_val[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_flag   <= 1'b0;
      cdb_rob_id <= '0;
      cdb_val    <= '0;
      cdb_src    <= '0;
    end else if (jump_wrong) begin
      cdb_flag <= 1'b0;
    end else if (rdy) begin
      cdb_flag <= win_found;
      if (win_found) begin
        cdb_rob_id <= q_tag[win][head[win]];
        cdb_val    <= q_val[win][head[win]];
        cdb_src    <= win;
      end
    end
  end

endmodule

`default_nettype wire
